// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multicycle RISC-V controller.
// Contents: FSM state enum, ALUOP / ImmSrc / ResultSrc / ALUSrcA / ALUSrcB
// codes, supported opcodes, ALUControl codes, and the ImmSrc decode helper.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    JAL      = 4'd9,
    BRANCH   = 4'd10,
    ILLEGAL  = 4'd11
  } state_e;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  function automatic logic [1:0] imm_src(input logic [6:0] opcode);
    case (opcode)
      OP_LOAD, OP_ITYPE: imm_src = IMM_I;
      OP_STORE:          imm_src = IMM_S;
      OP_BRANCH:         imm_src = IMM_B;
      OP_JAL:            imm_src = IMM_J;
      default:           imm_src = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Memory handshake between the controller and the memory system.
//   mem_req   : controller requests an access this cycle
//   MemWrite  : access is a write
//   AdrSrc    : address select (0 = PC, 1 = ALU result)
//   mem_ready : memory completes the current access this cycle
interface multicycle_ctrl_if;
  logic mem_req;
  logic MemWrite;
  logic AdrSrc;
  logic mem_ready;

  modport master (output mem_req, output MemWrite, output AdrSrc, input mem_ready);
  modport slave  (input mem_req, input MemWrite, input AdrSrc, output mem_ready);
endinterface

// File: rtl/alu_dec.sv
// ALU decoder: maps ALUOP plus instruction fields to the ALU operation.
//   aluop_i       : 00 add, 01 subtract, 10 decode from funct3/funct7
//   funct3_i      : instruction funct3
//   opb5_i        : op[5] (distinguishes R-type from I-type)
//   funct7b5_i    : funct7[5] (sub vs add for R-type)
//   alu_control_o : ALU operation code
module alu_dec
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] aluop_i,
  input  logic [2:0] funct3_i,
  input  logic       opb5_i,
  input  logic       funct7b5_i,
  output logic [2:0] alu_control_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    case (aluop_i)
      ALUOP_ADD: alu_control_o = ALU_ADD;
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          // addi never subtracts, so funct7[5] only matters for R-type
          3'b000:  alu_control_o = (opb5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control_o = ALU_SLT;
          3'b110:  alu_control_o = ALU_OR;
          3'b111:  alu_control_o = ALU_AND;
          default: alu_control_o = ALU_ADD;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore-FSM controller for a multicycle RISC-V datapath.
//   clk, rst_n              : clock, asynchronous active-low reset
//   op, funct3, funct7      : instruction register fields
//   Zero, Sign_Flag         : ALU flags for branch resolution
//   mem                     : memory handshake (mem_req/MemWrite/AdrSrc/mem_ready)
//   PCWrite, IRWrite, RegWrite : datapath strobes
//   ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl : datapath selects
//   illegal                 : sticky unsupported-opcode flag
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [6:0]          op,
  input  logic [2:0]          funct3,
  input  logic [6:0]          funct7,
  input  logic                Zero,
  input  logic                Sign_Flag,
  multicycle_ctrl_if.master   mem,
  output logic                PCWrite,
  output logic                IRWrite,
  output logic                RegWrite,
  output logic [1:0]          ResultSrc,
  output logic [1:0]          ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          ImmSrc,
  output logic [2:0]          ALUControl,
  output logic                illegal
);

  state_e     state_q, state_d;
  logic       req_d, pcw_d, irw_d, mw_d, rw_d, adr_d;
  logic [1:0] aluop_d;
  logic       branch_taken;
  logic       unused_funct7;

  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    case (funct3)
      3'b000:  branch_taken = Zero;
      3'b001:  branch_taken = ~Zero;
      3'b100:  branch_taken = Sign_Flag;
      default: branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    req_d     = 1'b0;
    pcw_d     = 1'b0;
    irw_d     = 1'b0;
    mw_d      = 1'b0;
    rw_d      = 1'b0;
    adr_d     = 1'b0;
    aluop_d   = ALUOP_ADD;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RD2;
    case (state_q)
      FETCH: begin
        req_d     = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
        if (mem.mem_ready) begin
          irw_d   = 1'b1;
          pcw_d   = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_RTYPE:          state_d = EXECR;
          OP_ITYPE:          state_d = EXECI;
          OP_JAL:            state_d = JAL;
          OP_BRANCH:         state_d = BRANCH;
          default:           state_d = ILLEGAL;
        endcase
      end
      MEMADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        state_d = op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        req_d = 1'b1;
        adr_d = 1'b1;
        if (mem.mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        ResultSrc = RES_DATA;
        rw_d      = 1'b1;
        state_d   = FETCH;
      end
      MEMWRITE: begin
        req_d = 1'b1;
        adr_d = 1'b1;
        mw_d  = 1'b1;
        if (mem.mem_ready) state_d = FETCH;
      end
      EXECR: begin
        ALUSrcA = SRCA_RD1;
        aluop_d = ALUOP_FUNCT;
        state_d = ALUWB;
      end
      EXECI: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        aluop_d = ALUOP_FUNCT;
        state_d = ALUWB;
      end
      ALUWB: begin
        rw_d    = 1'b1;
        state_d = FETCH;
      end
      JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        pcw_d   = 1'b1;
        state_d = ALUWB;
      end
      BRANCH: begin
        ALUSrcA = SRCA_RD1;
        aluop_d = ALUOP_SUB;
        pcw_d   = branch_taken;
        state_d = FETCH;
      end
      ILLEGAL: state_d = ILLEGAL;
      default: state_d = FETCH;
    endcase
  end

  // Strobes are gated by rst_n as well as the async state reset, because
  // FETCH (the reset state) itself requests memory.
  assign mem.mem_req  = rst_n & req_d;
  assign mem.MemWrite = rst_n & mw_d;
  assign mem.AdrSrc   = adr_d;
  assign PCWrite      = rst_n & pcw_d;
  assign IRWrite      = rst_n & irw_d;
  assign RegWrite     = rst_n & rw_d;
  assign illegal      = (state_q == ILLEGAL);
  assign ImmSrc       = imm_src(op);

  alu_dec u_alu_dec (
    .aluop_i       (aluop_d),
    .funct3_i      (funct3),
    .opb5_i        (op[5]),
    .funct7b5_i    (funct7[5]),
    .alu_control_o (ALUControl)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios followed by
// random instruction streams, compared cycle by cycle against a per-
// instruction expected output plan derived from instruction semantics.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op, funct7;
  logic [2:0] funct3;
  logic       Zero, Sign_Flag;
  logic       PCWrite, IRWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;

  multicycle_ctrl_if mem_if ();

  multicycle_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .funct3     (funct3),
    .funct7     (funct7),
    .Zero       (Zero),
    .Sign_Flag  (Sign_Flag),
    .mem        (mem_if.master),
    .PCWrite    (PCWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  typedef enum int { K_LW, K_SW, K_R, K_I, K_JAL, K_BR, K_BAD } kind_t;

  // strobes = {mem_req, PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc}
  typedef struct packed {
    logic [5:0] strobes;
    logic [1:0] res;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [2:0] alu;
    logic [1:0] imm;
    logic       ill;
  } obs_t;

  typedef struct packed {
    logic rdy;
    obs_t e;
  } step_t;

  localparam logic [2:0] A_ADD = 3'b000;
  localparam logic [2:0] A_SUB = 3'b001;
  localparam logic [2:0] A_AND = 3'b010;
  localparam logic [2:0] A_OR  = 3'b011;
  localparam logic [2:0] A_SLT = 3'b101;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  step_t       plan[$];
  logic [1:0]  cur_imm;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic obs_t observe();
    return '{{mem_if.mem_req, PCWrite, IRWrite, mem_if.MemWrite, RegWrite, mem_if.AdrSrc},
             ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal};
  endfunction

  function automatic obs_t mk(input logic [5:0] s, input logic [1:0] rs, input logic [1:0] sa,
                              input logic [1:0] sb, input logic [2:0] alu, input logic [1:0] imm,
                              input logic ill);
    return '{s, rs, sa, sb, alu, imm, ill};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [6:0] op_of(input kind_t k);
    case (k)
      K_LW:    return 7'b0000011;
      K_SW:    return 7'b0100011;
      K_R:     return 7'b0110011;
      K_I:     return 7'b0010011;
      K_JAL:   return 7'b1101111;
      K_BR:    return 7'b1100011;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [1:0] imm_of(input kind_t k);
    case (k)
      K_LW, K_I: return 2'b00;
      K_SW:      return 2'b01;
      K_BR:      return 2'b10;
      K_JAL:     return 2'b11;
      default:   return 2'b00;
    endcase
  endfunction

  // Arithmetic operation the instruction asks of the ALU.
  function automatic logic [2:0] alu_of(input kind_t k, input logic [2:0] f3, input logic [6:0] f7);
    case (f3)
      3'b000:  return (k == K_R && f7[5]) ? A_SUB : A_ADD;
      3'b010:  return A_SLT;
      3'b110:  return A_OR;
      3'b111:  return A_AND;
      default: return A_ADD;
    endcase
  endfunction

  function automatic logic taken_of(input logic [2:0] f3, input logic z, input logic s);
    case (f3)
      3'b000:  return z;      // beq: equal
      3'b001:  return !z;     // bne: not equal
      3'b100:  return s;      // blt: less than
      default: return 1'b0;
    endcase
  endfunction

  task automatic build_plan(input kind_t k, input logic [2:0] f3, input logic [6:0] f7,
                            input logic z, input logic s,
                            input int unsigned fst, input int unsigned mst);
    logic [1:0] im;
    im = imm_of(k);
    plan.delete();
    for (int unsigned i = 0; i < fst; i++)
      plan.push_back('{1'b0, mk(6'b100000, 2'b10, 2'b00, 2'b10, A_ADD, im, 1'b0)});
    plan.push_back('{1'b1, mk(6'b111000, 2'b10, 2'b00, 2'b10, A_ADD, im, 1'b0)});
    plan.push_back('{rb(), mk(6'b000000, 2'b00, 2'b01, 2'b01, A_ADD, im, 1'b0)});
    case (k)
      K_LW, K_SW: begin
        logic [5:0] acc;
        acc = (k == K_SW) ? 6'b100101 : 6'b100001;
        plan.push_back('{rb(), mk(6'b000000, 2'b00, 2'b10, 2'b01, A_ADD, im, 1'b0)});
        for (int unsigned i = 0; i < mst; i++)
          plan.push_back('{1'b0, mk(acc, 2'b00, 2'b00, 2'b00, A_ADD, im, 1'b0)});
        plan.push_back('{1'b1, mk(acc, 2'b00, 2'b00, 2'b00, A_ADD, im, 1'b0)});
        if (k == K_LW)
          plan.push_back('{rb(), mk(6'b000010, 2'b01, 2'b00, 2'b00, A_ADD, im, 1'b0)});
      end
      K_R, K_I: begin
        plan.push_back('{rb(), mk(6'b000000, 2'b00, 2'b10, (k == K_I) ? 2'b01 : 2'b00,
                                  alu_of(k, f3, f7), im, 1'b0)});
        plan.push_back('{rb(), mk(6'b000010, 2'b00, 2'b00, 2'b00, A_ADD, im, 1'b0)});
      end
      K_JAL: begin
        plan.push_back('{rb(), mk(6'b010000, 2'b00, 2'b01, 2'b10, A_ADD, im, 1'b0)});
        plan.push_back('{rb(), mk(6'b000010, 2'b00, 2'b00, 2'b00, A_ADD, im, 1'b0)});
      end
      K_BR:
        plan.push_back('{rb(), mk({1'b0, taken_of(f3, z, s), 4'b0000}, 2'b00, 2'b10, 2'b00,
                                  A_SUB, im, 1'b0)});
      default:
        for (int unsigned i = 0; i < 10; i++)
          plan.push_back('{rb(), mk(6'b000000, 2'b00, 2'b00, 2'b00, A_ADD, im, 1'b1)});
    endcase
  endtask

  // Called at posedge+1; drives the instruction fields for the next fetch.
  task automatic set_instr(input kind_t k, input logic [2:0] f3, input logic [6:0] f7,
                           input logic z, input logic s);
    op        = op_of(k);
    funct3    = f3;
    funct7    = f7;
    Zero      = z;
    Sign_Flag = s;
    cur_imm   = imm_of(k);
  endtask

  task automatic run_plan(input string name);
    for (int i = 0; i < plan.size(); i++) begin
      mem_if.mem_ready = plan[i].rdy;
      @(negedge clk);
      check_eq($sformatf("%s.c%0d", name, i + 1), 32'(observe()), 32'(plan[i].e));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic exec(input kind_t k, input logic [2:0] f3, input logic [6:0] f7,
                      input logic z, input logic s, input int unsigned fst,
                      input int unsigned mst, input string name);
    set_instr(k, f3, f7, z, s);
    build_plan(k, f3, f7, z, s, fst, mst);
    run_plan(name);
  endtask

  task automatic do_reset(input string name);
    rst_n            = 1'b0;
    mem_if.mem_ready = 1'b0;
    #1;
    check_eq({name, ".strobes"},
             32'({mem_if.mem_req, PCWrite, IRWrite, mem_if.MemWrite, RegWrite, illegal}), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq({name, ".fetch"}, 32'(observe()),
             32'(mk(6'b100000, 2'b10, 2'b00, 2'b10, A_ADD, cur_imm, 1'b0)));
    @(posedge clk);
    #1;
  endtask

  initial begin
    kind_t       k;
    logic [2:0]  f3;
    logic [6:0]  f7;
    rst_n            = 1'b0;
    op               = '0;
    funct3           = '0;
    funct7           = '0;
    Zero             = 1'b0;
    Sign_Flag        = 1'b0;
    mem_if.mem_ready = 1'b0;
    cur_imm          = 2'b00;
    #12;
    do_reset("rst0");

    exec(K_R,  3'b000, 7'b0000000, 1'b0, 1'b0, 0, 0, "add");
    exec(K_LW, 3'b010, 7'b0000000, 1'b0, 1'b0, 0, 2, "lw");
    exec(K_BR, 3'b001, 7'b0000000, 1'b0, 1'b0, 0, 0, "bne_nz");
    exec(K_BR, 3'b001, 7'b0000000, 1'b1, 1'b0, 0, 0, "bne_z");
    exec(K_BR, 3'b100, 7'b0000000, 1'b0, 1'b1, 0, 0, "blt");
    exec(K_SW, 3'b010, 7'b0000000, 1'b0, 1'b0, 0, 0, "sw");
    exec(K_R,  3'b000, 7'b0100000, 1'b0, 1'b0, 1, 0, "sub");
    exec(K_JAL, 3'b000, 7'b0000000, 1'b0, 1'b0, 0, 0, "jal");
    exec(K_BAD, 3'b000, 7'b0000000, 1'b0, 1'b0, 0, 0, "bad");
    do_reset("rst_ill");

    // Store stalled in MEMWRITE, then reset lands mid-access.
    set_instr(K_SW, 3'b010, 7'b0000000, 1'b0, 1'b0);
    build_plan(K_SW, 3'b010, 7'b0000000, 1'b0, 1'b0, 0, 1);
    void'(plan.pop_back());
    run_plan("sw_abort");
    do_reset("rst_mw");
    exec(K_R, 3'b110, 7'b0000000, 1'b0, 1'b0, 0, 0, "or_after");

    for (int n = 0; n < 80; n++) begin
      k  = kind_t'($urandom_range(0, 5));
      f3 = 3'($urandom_range(0, 7));
      f7 = 7'($urandom);
      exec(k, f3, f7, rb(), rb(), $urandom_range(0, 2), $urandom_range(0, 2),
           $sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 op, funct3, funct7  input  7/3/7  fields of the instruction register.
REQ-005 Zero, Sign_Flag  input  1/1  ALU flags, valid in the cycle the ALU is driven.
REQ-006 mem_ready  input  1  memory completes the current access this cycle.
REQ-007 mem_req  output  1  memory access requested.
REQ-008 PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc  output  1 each  datapath strobes and selects.
REQ-009 ResultSrc, ALUSrcA, ALUSrcB, ImmSrc  output  2 each  datapath selects.
REQ-010 ALUControl  output  3  ALU operation.
REQ-011 illegal  output  1  sticky flag for an unsupported opcode.

Function
REQ-012 The FSM SHALL be Moore with these states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, JAL, BRANCH, ILLEGAL.
REQ-013 FETCH SHALL drive mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOP=00 and ResultSrc=10, assert IRWrite and PCWrite only when mem_ready=1, hold while mem_ready=0, and advance to DECODE when mem_ready=1.
REQ-014 DECODE SHALL drive ALUSrcA=01, ALUSrcB=01 and ALUOP=00 (branch target) and dispatch on op: 0000011 or 0100011 go to MEMADR, 0110011 to EXECR, 0010011 to EXECI, 1101111 to JAL, 1100011 to BRANCH, and any other op to ILLEGAL.
REQ-015 MEMADR SHALL drive ALUSrcA=10, ALUSrcB=01 and ALUOP=00, then go to MEMREAD if op[5]=0 and to MEMWRITE if op[5]=1.
REQ-016 MEMREAD SHALL drive mem_req=1, AdrSrc=1 and ResultSrc=00, hold until mem_ready, then go to MEMWB.
REQ-017 MEMWB SHALL drive ResultSrc=01 and RegWrite=1, then go to FETCH.
REQ-018 MEMWRITE SHALL drive mem_req=1, AdrSrc=1 and ResultSrc=00, assert MemWrite for every cycle in the state, and go to FETCH on mem_ready.
REQ-019 EXECR SHALL drive ALUSrcA=10, ALUSrcB=00 and ALUOP=10; EXECI SHALL drive ALUSrcA=10, ALUSrcB=01 and ALUOP=10; both SHALL then go to ALUWB.
REQ-020 ALUWB SHALL drive ResultSrc=00 and RegWrite=1, then go to FETCH.
REQ-021 JAL SHALL drive ALUSrcA=01, ALUSrcB=10, ALUOP=00, ResultSrc=00 and PCWrite=1, then go to ALUWB.
REQ-022 BRANCH SHALL drive ALUSrcA=10, ALUSrcB=00, ALUOP=01 and ResultSrc=00, set PCWrite=Zero for funct3=000, ~Zero for 001, Sign_Flag for 100 and 0 otherwise, then go to FETCH.
REQ-023 ILLEGAL SHALL be absorbing, with illegal=1 and all strobes 0, until reset.
REQ-024 ImmSrc SHALL be decoded combinationally from op as I-type 00, S-type 01, B-type 10, J-type 11, and 00 for any other op.
REQ-025 ALUControl SHALL be derived from ALUOP, funct3, funct7 and op[5] using the standard ALU-decoder mapping.
REQ-026 With zero-wait memory, latency SHALL be 3 cycles for a branch, 4 for R, I, sw and jal, and 5 for lw; each mem_ready=0 cycle SHALL add one cycle.
REQ-027 Every select not listed for a state SHALL be driven to 0, so no output is X in any state.

Reset
REQ-028 While rst_n=0, the state SHALL be FETCH, illegal SHALL be 0, and mem_req, PCWrite, IRWrite, MemWrite and RegWrite SHALL be forced to 0.
REQ-029 Reset asserted mid-access SHALL abort the access immediately, and the block SHALL restart in FETCH on the first clk edge after rst_n rises.

Structure
REQ-030 The state encoding (4-bit localparams) and the ALUOP, ImmSrc, ResultSrc and ALUSrc codes SHALL live in a shared package, riscv_ctrl_pkg.
REQ-031 The block SHALL instantiate the existing alu_dec as its only sub-module; the FSM and branch-condition logic SHALL stay in multicycle_ctrl.

Verification
REQ-032 The bench SHALL cover: reset, then add (op=0110011, funct3=000, funct7=0000000) with mem_ready=1 -> states FETCH, DECODE, EXECR, ALUWB, with RegWrite=1 only in cycle 4 and ALUControl=000 in EXECR.
REQ-033 The bench SHALL cover: lw (op=0000011) with mem_ready low for 2 cycles in MEMREAD -> 7 cycles total, RegWrite=1 with ResultSrc=01 once, and MemWrite never 1.
REQ-034 The bench SHALL cover: bne (funct3=001) with Zero=0 -> PCWrite=1 in BRANCH; the same instruction with Zero=1 -> PCWrite=0; blt (funct3=100) with Sign_Flag=1 -> PCWrite=1.
REQ-035 The bench SHALL cover: sw (op=0100011) with mem_ready=1 -> MemWrite=1 for exactly 1 cycle and AdrSrc=1 in MEMWRITE.
REQ-036 The bench SHALL cover: op=1111111 -> ILLEGAL, with illegal=1 held for 10 cycles and strobes 0; then rst_n=0 -> illegal=0 and state FETCH.
REQ-037 The bench SHALL cover: rst_n pulsed low in MEMWRITE with mem_ready=0 -> MemWrite and mem_req drop asynchronously, then fetch resumes.
